// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, R-type functs, ALU encodings and
// the control bundle that travels down the pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       Branch;
        logic       RegDst;
        logic       regWrite;
        logic       alu_scr;
        logic [3:0] alu_op;
        logic       MemToReg;
        logic       MemWrite;
        logic       MemRead;
    } ctrl_t;

endpackage

// File: rtl/main_control.sv
// Combinational main decoder: opcode/funct to control bundle, plus an illegal
// flag and whether the instruction uses rt as a source operand.
module main_control
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_illegal,
    output logic       o_reads_rt
);

    always_comb begin
        o_ctrl     = '0;
        o_illegal  = 1'b0;
        o_reads_rt = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.RegDst   = 1'b1;
                o_ctrl.regWrite = 1'b1;
                o_reads_rt      = 1'b1;
                case (i_funct)
                    FN_ADD:  o_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  o_ctrl.alu_op = ALU_SUB;
                    FN_AND:  o_ctrl.alu_op = ALU_AND;
                    FN_OR:   o_ctrl.alu_op = ALU_OR;
                    FN_NOR:  o_ctrl.alu_op = ALU_NOR;
                    FN_SLT:  o_ctrl.alu_op = ALU_SLT;
                    default: o_illegal     = 1'b1;
                endcase
            end
            OP_LW: begin
                o_ctrl.alu_scr  = 1'b1;
                o_ctrl.MemToReg = 1'b1;
                o_ctrl.MemRead  = 1'b1;
                o_ctrl.regWrite = 1'b1;
                o_ctrl.alu_op   = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl.alu_scr  = 1'b1;
                o_ctrl.MemWrite = 1'b1;
                o_ctrl.alu_op   = ALU_ADD;
                o_reads_rt      = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.Branch = 1'b1;
                o_ctrl.alu_op = ALU_SUB;
                o_reads_rt    = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.alu_scr  = 1'b1;
                o_ctrl.regWrite = 1'b1;
                o_ctrl.alu_op   = ALU_ADD;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with ID/EX pipeline register, load-use hazard detection
// (stall + bubble) and a saturating stall-cycle counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc4,
    input  logic                   flush,
    output logic                   stall_o,
    output logic                   ex_valid,
    output logic                   ex_Branch,
    output logic                   ex_RegDst,
    output logic                   ex_regWrite,
    output logic                   ex_alu_scr,
    output logic                   ex_MemToReg,
    output logic                   ex_MemWrite,
    output logic                   ex_MemRead,
    output logic [3:0]             ex_alu_op,
    output logic [4:0]             ex_rs,
    output logic [4:0]             ex_rt,
    output logic [4:0]             ex_rd,
    output logic [31:0]            ex_imm,
    output logic [31:0]            ex_pc4,
    output logic                   illegal_o,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    ctrl_t                  w_ctrl;
    logic                   w_illegal;
    logic                   w_reads_rt;
    logic                   w_hz;
    logic                   w_stall;
    logic [4:0]             w_rs;
    logic [4:0]             w_rt;

    logic                   r_valid;
    ctrl_t                  r_ctrl;
    logic [4:0]             r_rs;
    logic [4:0]             r_rt;
    logic [4:0]             r_rd;
    logic [31:0]            r_imm;
    logic [31:0]            r_pc4;
    logic                   r_illegal;
    logic [STALL_CNT_W-1:0] r_cnt;

    main_control u_main_control (
        .i_opcode   (if_instr[31:26]),
        .i_funct    (if_instr[5:0]),
        .o_ctrl     (w_ctrl),
        .o_illegal  (w_illegal),
        .o_reads_rt (w_reads_rt)
    );

    assign w_rs = if_instr[25:21];
    assign w_rt = if_instr[20:16];

    // rs is compared for every opcode; rt only where it is a true source.
    assign w_hz = r_valid && r_ctrl.MemRead && (r_rt != 5'd0) && if_valid &&
                  ((r_rt == w_rs) || (w_reads_rt && (r_rt == w_rt)));
    assign w_stall = w_hz && !flush;
    assign stall_o = w_stall;

    always_ff @(posedge clk) begin
        // Default every cycle is a bubble; only a clean, legal instruction loads.
        r_valid   <= 1'b0;
        r_ctrl    <= '0;
        r_rs      <= '0;
        r_rt      <= '0;
        r_rd      <= '0;
        r_imm     <= '0;
        r_pc4     <= '0;
        r_illegal <= 1'b0;
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            if (w_stall && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
            if (!flush && !w_hz && if_valid) begin
                if (w_illegal) begin
                    r_illegal <= 1'b1;
                end else begin
                    r_valid <= 1'b1;
                    r_ctrl  <= w_ctrl;
                    r_rs    <= w_rs;
                    r_rt    <= w_rt;
                    r_rd    <= if_instr[15:11];
                    r_imm   <= {{16{if_instr[15]}}, if_instr[15:0]};
                    r_pc4   <= if_pc4;
                end
            end
        end
    end

    assign ex_valid    = r_valid;
    assign ex_Branch   = r_ctrl.Branch;
    assign ex_RegDst   = r_ctrl.RegDst;
    assign ex_regWrite = r_ctrl.regWrite;
    assign ex_alu_scr  = r_ctrl.alu_scr;
    assign ex_MemToReg = r_ctrl.MemToReg;
    assign ex_MemWrite = r_ctrl.MemWrite;
    assign ex_MemRead  = r_ctrl.MemRead;
    assign ex_alu_op   = r_ctrl.alu_op;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign ex_imm      = r_imm;
    assign ex_pc4      = r_pc4;
    assign illegal_o   = r_illegal;
    assign stall_cnt   = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed plan steps then random
// instruction streams, all checked against a table-driven reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        flush;

    logic        stall_o, ex_valid, ex_Branch, ex_RegDst, ex_regWrite, ex_alu_scr;
    logic        ex_MemToReg, ex_MemWrite, ex_MemRead, illegal_o;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_imm, ex_pc4;
    logic [15:0] stall_cnt;

    logic        s_stall_o, s_ex_valid, s_ex_Branch, s_ex_RegDst, s_ex_regWrite, s_ex_alu_scr;
    logic        s_ex_MemToReg, s_ex_MemWrite, s_ex_MemRead, s_illegal_o;
    logic [3:0]  s_ex_alu_op;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
    logic [31:0] s_ex_imm, s_ex_pc4;
    logic [1:0]  s_stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
        .flush(flush), .stall_o(stall_o), .ex_valid(ex_valid), .ex_Branch(ex_Branch),
        .ex_RegDst(ex_RegDst), .ex_regWrite(ex_regWrite), .ex_alu_scr(ex_alu_scr),
        .ex_MemToReg(ex_MemToReg), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
        .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_pc4(ex_pc4), .illegal_o(illegal_o), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.STALL_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
        .flush(flush), .stall_o(s_stall_o), .ex_valid(s_ex_valid), .ex_Branch(s_ex_Branch),
        .ex_RegDst(s_ex_RegDst), .ex_regWrite(s_ex_regWrite), .ex_alu_scr(s_ex_alu_scr),
        .ex_MemToReg(s_ex_MemToReg), .ex_MemWrite(s_ex_MemWrite), .ex_MemRead(s_ex_MemRead),
        .ex_alu_op(s_ex_alu_op), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
        .ex_imm(s_ex_imm), .ex_pc4(s_ex_pc4), .illegal_o(s_illegal_o), .stall_cnt(s_stall_cnt)
    );

    // Reference state: what ID/EX should hold, expressed as plain values.
    logic        m_valid, m_illegal;
    logic [10:0] m_ctrl;   // {Branch,RegDst,regWrite,alu_scr,alu_op,MemToReg,MemWrite,MemRead}
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_imm, m_pc4;
    int          m_stalls;
    bit          m_known = 0;

    // Architectural meaning of each instruction as a lookup.
    function automatic void ref_decode(input logic [31:0] ins, output logic legal,
                                       output logic [10:0] c, output logic src_rt);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        legal = 1'b1; c = '0; src_rt = 1'b0;
        if (op == 'h00) begin
            src_rt = 1'b1;
            if      (fn == 'h20) c = 11'b0_1_1_0_0010_000;
            else if (fn == 'h22) c = 11'b0_1_1_0_0110_000;
            else if (fn == 'h24) c = 11'b0_1_1_0_0000_000;
            else if (fn == 'h25) c = 11'b0_1_1_0_0001_000;
            else if (fn == 'h27) c = 11'b0_1_1_0_1100_000;
            else if (fn == 'h2A) c = 11'b0_1_1_0_0111_000;
            else begin legal = 1'b0; c = '0; end
        end
        else if (op == 'h23) c = 11'b0_0_1_1_0010_101;
        else if (op == 'h2B) begin c = 11'b0_0_0_1_0010_010; src_rt = 1'b1; end
        else if (op == 'h04) begin c = 11'b1_0_0_0_0110_000; src_rt = 1'b1; end
        else if (op == 'h08) c = 11'b0_0_1_1_0010_000;
        else legal = 1'b0;
    endfunction

    function automatic logic model_stall();
        logic legal, src_rt;
        logic [10:0] c;
        logic hz;
        ref_decode(if_instr, legal, c, src_rt);
        hz = m_valid && m_ctrl[0] && (m_rt != 0) && if_valid &&
             ((m_rt == if_instr[25:21]) || (src_rt && m_rt == if_instr[20:16]));
        return hz;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sat16 = (m_stalls > 65535) ? 65535 : m_stalls;
        int sat2  = (m_stalls > 3) ? 3 : m_stalls;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ctrl", 32'({ex_Branch, ex_RegDst, ex_regWrite, ex_alu_scr, ex_alu_op,
                         ex_MemToReg, ex_MemWrite, ex_MemRead}), 32'(m_ctrl));
        chk("fields", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m_rs, m_rt, m_rd});
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_pc4", ex_pc4, m_pc4);
        chk("illegal_o", 32'(illegal_o), 32'(m_illegal));
        chk("stall_cnt", 32'(stall_cnt), 32'(sat16));
        chk("sat_ctrl", 32'({s_ex_valid, s_ex_Branch, s_ex_RegDst, s_ex_regWrite, s_ex_alu_scr,
                             s_ex_alu_op, s_ex_MemToReg, s_ex_MemWrite, s_ex_MemRead, s_illegal_o}),
                        32'({m_valid, m_ctrl, m_illegal}));
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(sat2));
    endtask

    // One clock: drive inputs, check the combinational stall, clock, advance model, check.
    task automatic cycle(input logic r, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic f, output logic was_stall);
        logic legal, src_rt, hz;
        logic [10:0] c;
        rst = r; if_valid = v; if_instr = ins; if_pc4 = pc; flush = f;
        #1;
        hz = m_known ? model_stall() : 1'b0;
        was_stall = hz && !f;
        if (m_known) begin
            chk("stall_o", 32'(stall_o), 32'(was_stall));
            chk("sat_stall_o", 32'(s_stall_o), 32'(was_stall));
        end
        @(posedge clk);
        ref_decode(ins, legal, c, src_rt);
        m_valid = 0; m_ctrl = '0; m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0; m_pc4 = 0; m_illegal = 0;
        if (!r) begin
            m_stalls = 0;
            m_known  = 1;
        end else if (m_known) begin
            if (was_stall) m_stalls++;
            if (!f && !hz && v) begin
                if (!legal) m_illegal = 1;
                else begin
                    m_valid = 1; m_ctrl = c;
                    m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11];
                    m_imm = 32'($signed(ins[15:0])); m_pc4 = pc;
                end
            end
        end
        #1;
        if (m_known) check_all();
        $display("t=%0t rst=%0b v=%0b instr=%h flush=%0b stall=%0b ex_valid=%0b ill=%0b cnt=%0d",
                 $time, r, v, ins, f, was_stall, ex_valid, illegal_o, stall_cnt);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [6];
        logic [5:0] fns [7];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3B};
        op = ops[$urandom_range(0, 5)];
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
        fn = (op == 6'h00) ? fns[$urandom_range(0, 6)] : 6'($urandom);
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom), 5'($urandom), fn};
    endfunction

    initial begin
        logic st;
        logic [31:0] ins;
        rst = 0; if_valid = 0; if_instr = 0; if_pc4 = 0; flush = 0;
        m_valid = 0; m_ctrl = '0; m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0; m_pc4 = 0;
        m_illegal = 0; m_stalls = 0;
        @(negedge clk);

        // Reset with garbage on the inputs.
        cycle(0, 1, 32'h8C220004, 32'hDEADBEEF, 0, st);
        cycle(0, 1, 32'h8C420004, 32'h12345678, 1, st);
        chk("reset_stall_o", 32'(stall_o), 32'd0);

        // add $3,$1,$2
        cycle(1, 1, 32'h00221820, 32'h00000104, 0, st);
        chk("add_rd", 32'(ex_rd), 32'd3);

        // lw then dependent add: one stall, bubble, then the add.
        cycle(1, 1, 32'h8C220004, 32'h00000108, 0, st);
        cycle(1, 1, 32'h00421820, 32'h0000010C, 0, st);
        chk("lu_stalled", 32'(st), 32'd1);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        cycle(1, 1, 32'h00421820, 32'h0000010C, 0, st);
        chk("lu_no_second_stall", 32'(st), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // Same pair with flush in the hazard cycle.
        cycle(1, 1, 32'h8C220004, 32'h00000110, 0, st);
        cycle(1, 1, 32'h00421820, 32'h00000114, 1, st);
        chk("flush_no_stall", 32'(stall_o), 32'd0);
        chk("flush_cnt", 32'(stall_cnt), 32'd1);

        // sw with negative offset.
        cycle(1, 1, 32'hAC22FFFC, 32'h00000118, 0, st);
        chk("sw_imm", ex_imm, 32'hFFFFFFFC);

        // Illegal opcode: bubble plus single-cycle pulse.
        cycle(1, 1, 32'hFC000000, 32'h0000011C, 0, st);
        chk("illegal_pulse", 32'(illegal_o), 32'd1);
        cycle(1, 0, 32'h00000000, 32'h00000120, 0, st);
        chk("illegal_clear", 32'(illegal_o), 32'd0);

        // $0 as load target never stalls.
        cycle(1, 1, 32'h8C200004, 32'h00000124, 0, st);
        cycle(1, 1, 32'h00000820, 32'h00000128, 0, st);
        chk("zero_no_stall", 32'(st), 32'd0);

        // Five more load-use pairs: narrow counter saturates.
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 32'h8C220004, 32'h00000200, 0, st);
            cycle(1, 1, 32'h00421820, 32'h00000204, 0, st);
            cycle(1, 1, 32'h00421820, 32'h00000204, 0, st);
        end
        chk("sat_cnt_3", 32'(s_stall_cnt), 32'd3);
        chk("wide_cnt_6", 32'(stall_cnt), 32'd6);

        // Reset during a stall cycle: reset wins, nothing counted.
        cycle(1, 1, 32'h8C220004, 32'h00000300, 0, st);
        cycle(0, 1, 32'h00421820, 32'h00000304, 0, st);
        chk("rst_in_stall_cnt", 32'(stall_cnt), 32'd0);

        // Random stream; a stalled instruction is held like a real fetch stage would.
        ins = rand_instr();
        for (int n = 0; n < 250; n++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0), ins,
                  $urandom, ($urandom_range(0, 9) == 0), st);
            if (!st) ins = rand_instr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Instruction-decode stage and ID/EX pipeline register of the pipelined MIPS core. It decodes the 32-bit instruction from the IF/ID register into the control bundle consumed by the execute datapath (Branch, RegDst, regWrite, alu_scr, alu_op, MemToReg, MemWrite, MemRead), registers it with the operand fields, and detects load-use hazards. On a hazard it stalls fetch and inserts a bubble. Upstream is the fetch stage; downstream is the ALU / data-memory datapath.

## Interface
- STALL_CNT_W, 16: width of the saturating load-use stall counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_valid  in  1  IF/ID register holds a real instruction.
- if_instr  in  32  instruction word from IF/ID.
- if_pc4  in  32  PC+4 of that instruction.
- flush  in  1  branch taken in EX; squash the instruction currently in ID.
- stall_o  out  1  combinational; hold PC and IF/ID (PC en = ~stall_o).
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_Branch, ex_RegDst, ex_regWrite, ex_alu_scr, ex_MemToReg, ex_MemWrite, ex_MemRead  out  1 each  registered control.
- ex_alu_op  out  4  registered ALU operation.
- ex_rs, ex_rt, ex_rd  out  5 each  register fields [25:21], [20:16], [15:11].
- ex_imm  out  32  sign-extended instr[15:0].
- ex_pc4  out  32  registered if_pc4.
- illegal_o  out  1  one-cycle pulse, registered: unsupported opcode/funct reached ID.
- stall_cnt  out  STALL_CNT_W  number of stall cycles, saturating.

## Operation
- Decode, opcode instr[31:26]:
  - 0x00 R-type: RegDst=1, regWrite=1. alu_op from funct: 0x20 add→0010, 0x22 sub→0110, 0x24 and→0000, 0x25 or→0001, 0x27 nor→1100, 0x2A slt→0111.
  - 0x23 lw: alu_scr=1, MemToReg=1, MemRead=1, regWrite=1, alu_op=0010.
  - 0x2B sw: alu_scr=1, MemWrite=1, alu_op=0010.
  - 0x04 beq: Branch=1, alu_op=0110.
  - 0x08 addi: alu_scr=1, regWrite=1, alu_op=0010.
  - Any other opcode, or any other funct under R-type, is illegal.
- Control signals not listed for an instruction are 0.
- Load-use hazard (hz) is asserted when all of the following hold: ex_valid, ex_MemRead, ex_rt≠0, if_valid, and ex_rt equals if_instr rs or if_instr rt.
  - The rt compare applies only for R-type, sw and beq; lw and addi do not read rt as a source.
- stall_o = hz & ~flush.
- Per cycle, next ID/EX contents, in priority order:
  1. rst=0: all zero.
  2. flush: bubble.
  3. hz: bubble.
  4. if_valid & illegal: bubble, illegal_o=1.
  5. if_valid: decoded instruction, ex_valid=1.
  6. Otherwise: bubble.
- Bubble: ex_valid=0 and every control output 0. Field and data outputs are don't-care but driven 0.
- stall_cnt increments on each cycle with stall_o=1 and holds at all-ones.

## Timing
- Decode-to-ID/EX latency is 1 cycle; stall_o is same-cycle combinational.
- Reset: every output is 0 the cycle after rst is sampled low, including stall_cnt and illegal_o. stall_o is then 0 because ex_valid=0.
- A stall lasts exactly 1 cycle per load-use pair. The bubble clears ex_MemRead, so hz falls the next cycle.
- flush and hz in the same cycle: flush wins, stall_o=0, bubble, counter does not increment.
- Reset asserted during a stall cycle: reset wins and no stall is counted.
- Register $0 never causes a hazard.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - funct constants;
  - ALU encodings ALU_AND/OR/ADD/SUB/SLT/NOR;
  - a packed ctrl_t struct of the eight control fields.
- Sub-module main_control (purely combinational): instr → ctrl_t + illegal.
- Hazard logic, priority mux and ID/EX register stay in id_ex_stage.

## Test plan
- Reset: drive rst=0 for 2 cycles with garbage inputs → all outputs 0, stall_o=0, stall_cnt=0.
- 0x00221820 (add $3,$1,$2), if_valid=1 → next cycle ex_valid=1, RegDst=1, regWrite=1, alu_op=0010, ex_rd=3.
- 0x8C220004 (lw $2,4($1)), then 0x00421820 (add $3,$2,$2), held because stall_o=1:
  - stall_o=1 for exactly one cycle; bubble in ID/EX; add appears one cycle later.
  - stall_cnt=1.
- Same lw/add pair with flush=1 in the hazard cycle → stall_o=0, bubble, stall_cnt unchanged.
- 0xAC22FFFC (sw) → ex_imm=0xFFFFFFFC, MemWrite=1, regWrite=0, alu_scr=1.
- 0xFC000000 (opcode 0x3F) → bubble, illegal_o high for exactly 1 cycle.
- STALL_CNT_W=2 with 5 hazards → stall_cnt saturates at 3.
